uart_cmd_ctrl: RTL and testbench
================================

Name: uart_cmd_ctrl

Overview:
- Command sequencer between the UART receiver and the on-board peripherals (baud-rate select, PWM, LED bank, seven-segment value).
- Assembles 4-byte frames from received bytes, validates them, and applies register writes.
- Queues a one-byte ACK/NAK for the UART transmitter.
- Defers baud-rate changes until the ACK byte has been handed off, so the ACK always goes out at the old rate.

Parameters:
- HEADER, 8'hA5, frame start byte.
- TIMEOUT_CYCLES, 312500, max clk cycles between bytes of one frame (≈3 byte times at 9600 baud, 100 MHz).
- CNT_W, 19, width of the inter-byte timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, 100 MHz.
- reset  in  1  synchronous, active-high reset.
- iRxData  in  8  received byte; valid only when iRxValid=1.
- iRxValid  in  1  one-cycle strobe per received byte.
- iAckReady  in  1  transmitter can accept oAckData this cycle.
- oAckData  out  8  response byte: 8'h06 ACK, 8'h15 NAK.
- oAckValid  out  1  response pending; held until accepted.
- oRate  out  2  baud select to the UART: 0=9600, 1=19200, 2=57600, 3=115200.
- oPwmDuty  out  8  PWM duty register.
- oLed  out  8  LED register.
- oSegData  out  8  seven-segment value register.
- oCfgStb  out  1  one-cycle pulse when any config register (including oRate) changes.
- oErrCnt  out  8  saturating count of NAKs plus timeouts.
- oBusy  out  1  high in every state except IDLE.

Behaviour:
- Reset (synchronous, overrides everything, including mid-frame or with an ACK pending):
  - All outputs go to 0; oRate=2'b00. The pending rate and the timeout counter are cleared.
  - Next state is IDLE.
- Frame format: HEADER, CMD, DATA, CSUM. Valid when CSUM == CMD ^ DATA.
- Commands:
  - 8'h01 sets the pending rate to DATA[1:0].
  - 8'h02 writes oPwmDuty.
  - 8'h03 writes oLed.
  - 8'h04 writes oSegData.
  - Any other CMD gives a NAK.
- State machine:
  - IDLE: a byte equal to HEADER goes to CMD. Any other byte is silently ignored and is not an error.
  - CMD: the next byte is latched as CMD and the state goes to DATA. A byte equal to HEADER is still treated as CMD; there is no resync.
  - DATA: the next byte is latched as DATA and the state goes to CSUM.
  - CSUM: on the checksum byte (cycle N), the state goes to RESP at N+1.
  - RESP, entered at cycle N+1:
    - oAckValid=1 and oAckData is ACK or NAK.
    - For valid commands 02/03/04, the target register updates at N+1 and oCfgStb pulses at N+1. Registers are untouched on NAK.
    - Holds until the cycle where oAckValid && iAckReady (cycle M).
    - At M+1, oAckValid=0. The state goes to APPLY if the command was a valid 01, otherwise to IDLE.
  - APPLY: oRate takes the pending rate, oCfgStb pulses, and the state goes to IDLE, all in one cycle.
    - Writing the current rate still pulses oCfgStb.
- Timeout:
  - The counter resets on every accepted byte and counts only in CMD, DATA and CSUM.
  - When it reaches TIMEOUT_CYCLES-1 with no iRxValid that cycle, the state goes to IDLE. No response is sent and oErrCnt increments.
  - If iRxValid coincides with the terminal count, the byte wins and there is no timeout.
- Bytes arriving in RESP or APPLY are dropped and do not count as errors.
- oErrCnt increments on each NAK (at N+1) and each timeout, and saturates at 8'hFF.
- iAckReady may be held high continuously; the minimum oAckValid width is 1 cycle.

Test Plan:
- Reset with TIMEOUT_CYCLES=1000: A5,02,80,82 → at N+1 oPwmDuty=8'h80, oCfgStb pulses, oAckValid=1 with 8'h06. After iAckReady, oAckValid=0. oRate and oLed remain 0.
- Rate change: A5,01,03,02 with iAckReady held low for 50 cycles → oRate stays 0 while oAckValid=1. At M+1 oAckValid=0; at M+2 oRate=3 with an oCfgStb pulse.
- Bad checksum A5,03,5A,00 and unknown command A5,07,11,16 → two 8'h15 NAKs, oLed unchanged at 0, oErrCnt=2.
- Idle noise and drops:
  - 00,FF,3C before A5,04,25,21 → noise ignored, oSegData=8'h25, oErrCnt=0.
  - Bytes sent while oAckValid=1 are dropped; the following good frame is still parsed correctly.
- Timeout: A5,03 then silence for 1000 cycles → oBusy falls, no ACK is issued, oErrCnt=1. A complete frame afterwards parses normally.
  - A byte landing exactly on the terminal-count cycle is accepted.
- Reset mid-frame (after A5,02) and while oAckValid=1 → all outputs 0 the next cycle. A fresh frame A5,03,F0,F3 then sets oLed=8'hF0.

Source files
------------

// File: rtl/uart_cmd_ctrl.sv
// UART command sequencer: assembles HEADER/CMD/DATA/CSUM frames, writes config registers, and queues an ACK/NAK byte.
// Register writes and the ACK appear one cycle after CSUM. The ACK is held until iAckReady. Rate changes apply after the ACK handoff.
module uart_cmd_ctrl #(
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 312500,
  parameter int unsigned CNT_W          = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] iRxData,
  input  logic       iRxValid,
  input  logic       iAckReady,
  output logic [7:0] oAckData,
  output logic       oAckValid,
  output logic [1:0] oRate,
  output logic [7:0] oPwmDuty,
  output logic [7:0] oLed,
  output logic [7:0] oSegData,
  output logic       oCfgStb,
  output logic [7:0] oErrCnt,
  output logic       oBusy
);

  localparam logic [7:0]       ACK      = 8'h06;
  localparam logic [7:0]       NAK      = 8'h15;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_DATA, S_CSUM, S_RESP, S_APPLY
  } state_t;

  state_t           state_q;
  logic [7:0]       cmd_q, data_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       rate_pend_q, rate_q;
  logic             apply_q;
  logic [7:0]       ack_dat_q, pwm_q, led_q, seg_q, err_cnt_q, err_cnt_d;
  logic             ack_vld_q, cfg_stb_q;
  logic             frame_ok;

  assign frame_ok  = (iRxData == (cmd_q ^ data_q)) && (cmd_q >= 8'h01) && (cmd_q <= 8'h04);
  assign err_cnt_d = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      rate_pend_q <= '0;
      rate_q      <= '0;
      apply_q     <= 1'b0;
      ack_dat_q   <= '0;
      ack_vld_q   <= 1'b0;
      pwm_q       <= '0;
      led_q       <= '0;
      seg_q       <= '0;
      err_cnt_q   <= '0;
      cfg_stb_q   <= 1'b0;
    end else begin
      cfg_stb_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (iRxValid && iRxData == HEADER) state_q <= S_CMD;
        end
        S_CMD, S_DATA, S_CSUM: begin
          if (iRxValid) begin
            cnt_q <= '0;
            if (state_q == S_CMD) begin
              cmd_q   <= iRxData;
              state_q <= S_DATA;
            end else if (state_q == S_DATA) begin
              data_q  <= iRxData;
              state_q <= S_CSUM;
            end else begin
              state_q   <= S_RESP;
              ack_vld_q <= 1'b1;
              apply_q   <= frame_ok && (cmd_q == 8'h01);
              if (frame_ok) begin
                ack_dat_q <= ACK;
                case (cmd_q)
                  8'h01:   rate_pend_q <= data_q[1:0];
                  8'h02:   begin pwm_q <= data_q; cfg_stb_q <= 1'b1; end
                  8'h03:   begin led_q <= data_q; cfg_stb_q <= 1'b1; end
                  default: begin seg_q <= data_q; cfg_stb_q <= 1'b1; end
                endcase
              end else begin
                ack_dat_q <= NAK;
                err_cnt_q <= err_cnt_d;
              end
            end
          end else if (cnt_q == CNT_LAST) begin
            // Abandon the partial frame silently; only the error counter records it.
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            err_cnt_q <= err_cnt_d;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RESP: begin
          if (iAckReady) begin
            ack_vld_q <= 1'b0;
            state_q   <= apply_q ? S_APPLY : S_IDLE;
          end
        end
        S_APPLY: begin
          rate_q    <= rate_pend_q;
          cfg_stb_q <= 1'b1;
          apply_q   <= 1'b0;
          state_q   <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign oAckData  = ack_dat_q;
  assign oAckValid = ack_vld_q;
  assign oRate     = rate_q;
  assign oPwmDuty  = pwm_q;
  assign oLed      = led_q;
  assign oSegData  = seg_q;
  assign oCfgStb   = cfg_stb_q;
  assign oErrCnt   = err_cnt_q;
  assign oBusy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a short inter-byte timeout.
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] iRxData;
  logic       iRxValid;
  logic       iAckReady;
  logic [7:0] oAckData;
  logic       oAckValid;
  logic [1:0] oRate;
  logic [7:0] oPwmDuty, oLed, oSegData, oErrCnt;
  logic       oCfgStb, oBusy;

  int n_tests = 0;
  int n_fail  = 0;

  uart_cmd_ctrl #(.HEADER(8'hA5), .TIMEOUT_CYCLES(1000), .CNT_W(19)) dut (
    .clk(clk), .reset(reset), .iRxData(iRxData), .iRxValid(iRxValid),
    .iAckReady(iAckReady), .oAckData(oAckData), .oAckValid(oAckValid),
    .oRate(oRate), .oPwmDuty(oPwmDuty), .oLed(oLed), .oSegData(oSegData),
    .oCfgStb(oCfgStb), .oErrCnt(oErrCnt), .oBusy(oBusy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One-cycle byte strobe; returns half a cycle after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    iRxData  = b;
    iRxValid = 1'b1;
    @(negedge clk);
    iRxValid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] h, input logic [7:0] c,
                            input logic [7:0] d, input logic [7:0] s);
    send_byte(h);
    send_byte(c);
    send_byte(d);
    send_byte(s);
  endtask

  task automatic ack_once();
    @(negedge clk);
    iAckReady = 1'b1;
    @(negedge clk);
    iAckReady = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; iRxData = '0; iRxValid = 1'b0; iAckReady = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_ackv", oAckValid, 0);
    chk("rst_rate", oRate, 0);
    chk("rst_pwm", oPwmDuty, 0);
    chk("rst_err", oErrCnt, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_stb", oCfgStb, 0);

    // PWM write
    send_frame(8'hA5, 8'h02, 8'h80, 8'h82);
    chk("pwm_val", oPwmDuty, 8'h80);
    chk("pwm_stb", oCfgStb, 1);
    chk("pwm_ackv", oAckValid, 1);
    chk("pwm_ackd", oAckData, 8'h06);
    chk("pwm_busy", oBusy, 1);
    @(negedge clk);
    chk("pwm_stb_off", oCfgStb, 0);
    chk("pwm_ack_hold", oAckValid, 1);
    ack_once();
    chk("pwm_ackv_off", oAckValid, 0);
    chk("pwm_idle", oBusy, 0);
    chk("pwm_rate0", oRate, 0);
    chk("pwm_led0", oLed, 0);

    // Deferred rate change
    send_frame(8'hA5, 8'h01, 8'h03, 8'h02);
    chk("rate_nostb", oCfgStb, 0);
    repeat (50) @(negedge clk);
    chk("rate_ack_held", oAckValid, 1);
    chk("rate_ackd", oAckData, 8'h06);
    chk("rate_old", oRate, 0);
    ack_once();
    chk("rate_m1_ackv", oAckValid, 0);
    chk("rate_m1_old", oRate, 0);
    chk("rate_m1_stb", oCfgStb, 0);
    chk("rate_m1_busy", oBusy, 1);
    @(negedge clk);
    chk("rate_m2_new", oRate, 3);
    chk("rate_m2_stb", oCfgStb, 1);
    chk("rate_m2_idle", oBusy, 0);

    // NAKs: bad checksum, unknown command
    send_frame(8'hA5, 8'h03, 8'h5A, 8'h00);
    chk("nak1_ackd", oAckData, 8'h15);
    chk("nak1_err", oErrCnt, 1);
    chk("nak1_stb", oCfgStb, 0);
    ack_once();
    send_frame(8'hA5, 8'h07, 8'h11, 8'h16);
    chk("nak2_ackd", oAckData, 8'h15);
    chk("nak2_err", oErrCnt, 2);
    ack_once();
    chk("nak_led", oLed, 0);
    chk("nak_rate", oRate, 3);

    do_reset();
    chk("rst2_rate", oRate, 0);
    chk("rst2_err", oErrCnt, 0);

    // Idle noise, then drops while ACK pending
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h3C);
    chk("noise_idle", oBusy, 0);
    send_frame(8'hA5, 8'h04, 8'h25, 8'h21);
    chk("seg_val", oSegData, 8'h25);
    chk("seg_ackd", oAckData, 8'h06);
    chk("seg_err", oErrCnt, 0);
    send_byte(8'hA5); send_byte(8'h03); send_byte(8'h99);
    chk("drop_ack_held", oAckValid, 1);
    ack_once();
    chk("drop_idle", oBusy, 0);
    send_frame(8'hA5, 8'h03, 8'h0F, 8'h0C);
    chk("drop_led", oLed, 8'h0F);
    chk("drop_ackd", oAckData, 8'h06);
    chk("drop_err", oErrCnt, 0);
    ack_once();

    // Timeout
    send_byte(8'hA5); send_byte(8'h03);
    repeat (999) @(negedge clk);
    chk("to_busy_before", oBusy, 1);
    @(negedge clk);
    chk("to_busy_after", oBusy, 0);
    chk("to_err", oErrCnt, 1);
    chk("to_noack", oAckValid, 0);
    send_frame(8'hA5, 8'h04, 8'h77, 8'h73);
    chk("to_post_seg", oSegData, 8'h77);
    chk("to_post_ackd", oAckData, 8'h06);
    ack_once();

    // Byte exactly on the terminal count is accepted
    send_byte(8'hA5); send_byte(8'h03);
    repeat (998) @(negedge clk);
    send_byte(8'h44);
    chk("tc_busy", oBusy, 1);
    chk("tc_err", oErrCnt, 1);
    send_byte(8'h47);
    chk("tc_ackv", oAckValid, 1);
    chk("tc_ackd", oAckData, 8'h06);
    chk("tc_led", oLed, 8'h44);
    ack_once();

    // Reset mid-frame and with ACK pending
    send_byte(8'hA5); send_byte(8'h02);
    chk("mid_busy", oBusy, 1);
    do_reset();
    chk("mid_led", oLed, 0);
    chk("mid_seg", oSegData, 0);
    chk("mid_err", oErrCnt, 0);
    chk("mid_busy0", oBusy, 0);
    send_frame(8'hA5, 8'h02, 8'hAA, 8'hA8);
    chk("pend_pwm", oPwmDuty, 8'hAA);
    chk("pend_ackv", oAckValid, 1);
    do_reset();
    chk("pend_ackv0", oAckValid, 0);
    chk("pend_ackd0", oAckData, 0);
    chk("pend_pwm0", oPwmDuty, 0);
    chk("pend_busy0", oBusy, 0);
    send_frame(8'hA5, 8'h03, 8'hF0, 8'hF3);
    chk("fresh_led", oLed, 8'hF0);
    chk("fresh_ackd", oAckData, 8'h06);
    chk("fresh_ackv", oAckValid, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
